// File: rtl/param_universal_shift_register_if.sv
// Command/status bundle for param_universal_shift_register.
// master: command source (drives cmd_valid/control/operands/fill bits, observes outputs).
// slave : the shift register itself.
//   cmd_valid      command strobe, accepted only while busy==0
//   control[2:0]   operation select
//   shift_dir      multi-step direction (0 right, 1 left)
//   shift_amount   multi-step count, CNT_W bits
//   data_load      parallel load value
//   serial_in_msb  fill bit for right shifts
//   serial_in_lsb  fill bit for left shifts
//   out_final      register contents
//   serial_out_lsb out_final[0]
//   serial_out_msb out_final[WIDTH-1]
//   busy           multi-step operation in progress
//   done           one-cycle completion pulse
interface param_universal_shift_register_if #(
  parameter int WIDTH = 8
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic             cmd_valid;
  logic [2:0]       control;
  logic             shift_dir;
  logic [CNT_W-1:0] shift_amount;
  logic [WIDTH-1:0] data_load;
  logic             serial_in_msb;
  logic             serial_in_lsb;
  logic [WIDTH-1:0] out_final;
  logic             serial_out_lsb;
  logic             serial_out_msb;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, control, shift_dir, shift_amount, data_load,
           serial_in_msb, serial_in_lsb,
    input  out_final, serial_out_lsb, serial_out_msb, busy, done
  );

  modport slave (
    input  cmd_valid, control, shift_dir, shift_amount, data_load,
           serial_in_msb, serial_in_lsb,
    output out_final, serial_out_lsb, serial_out_msb, busy, done
  );
endinterface

// File: rtl/param_universal_shift_register.sv
// WIDTH-bit universal shift register: retain, load, SRL, SLL, ROR, ROL, ASR in one
// cycle, plus a multi-cycle shift-by-N engine (op 111) with busy/done handshake.
// Ports:
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset (aborts any multi-step operation)
//   bus      command/status bundle (slave side), see param_universal_shift_register_if
module param_universal_shift_register #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  param_universal_shift_register_if.slave       bus
);

  localparam int               CNT_W  = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);

  typedef enum logic {
    IDLE,
    SHIFTING
  } state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_count;
  logic             r_dir;
  logic             r_busy;
  logic             r_done;

  state_e           w_state_nxt;
  logic [WIDTH-1:0] w_data_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_dir_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;

  logic [CNT_W-1:0] w_amt;
  logic [WIDTH-1:0] w_srl;
  logic [WIDTH-1:0] w_sll;
  logic [WIDTH-1:0] w_ror;
  logic [WIDTH-1:0] w_rol;
  logic [WIDTH-1:0] w_asr;
  logic [WIDTH-1:0] w_multi;

  // Requested count saturates at WIDTH: further steps would only push in more fill.
  assign w_amt = (bus.shift_amount > LP_MAX) ? LP_MAX : bus.shift_amount;

  assign w_srl = {bus.serial_in_msb, r_data[WIDTH-1:1]};
  assign w_sll = {r_data[WIDTH-2:0], bus.serial_in_lsb};
  assign w_ror = {r_data[0], r_data[WIDTH-1:1]};
  assign w_rol = {r_data[WIDTH-2:0], r_data[WIDTH-1]};
  assign w_asr = {r_data[WIDTH-1], r_data[WIDTH-1:1]};

  // Multi-step uses the direction latched at accept but the fill bit seen live.
  assign w_multi = r_dir ? w_sll : w_srl;

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_count_nxt = r_count;
    w_dir_nxt   = r_dir;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.cmd_valid) begin
          w_done_nxt = 1'b1;
          case (bus.control)
            3'b000: w_data_nxt = r_data;
            3'b001: w_data_nxt = bus.data_load;
            3'b010: w_data_nxt = w_srl;
            3'b011: w_data_nxt = w_sll;
            3'b100: w_data_nxt = w_ror;
            3'b101: w_data_nxt = w_rol;
            3'b110: w_data_nxt = w_asr;
            3'b111: begin
              if (w_amt != '0) begin
                w_done_nxt  = 1'b0;
                w_busy_nxt  = 1'b1;
                w_count_nxt = w_amt;
                w_dir_nxt   = bus.shift_dir;
                w_state_nxt = SHIFTING;
              end
            end
          endcase
        end
      end

      SHIFTING: begin
        w_data_nxt = w_multi;
        if (r_count == LP_ONE) begin
          w_count_nxt = '0;
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_count_nxt = r_count - LP_ONE;
          w_busy_nxt  = 1'b1;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_data  <= RESET_VALUE;
      r_count <= '0;
      r_dir   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_count <= w_count_nxt;
      r_dir   <= w_dir_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign bus.out_final      = r_data;
  assign bus.serial_out_lsb = r_data[0];
  assign bus.serial_out_msb = r_data[WIDTH-1];
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;

endmodule
